// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared encodings and defaults for the TLB maintenance controller
package tlb_pkg;

  localparam int TLBNUM_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_WR   = 2'd0,
    OP_FILL = 2'd1,
    OP_INV  = 2'd2
  } req_op_e;

  localparam logic [2:0] INVTLB_ALL0        = 3'd0;
  localparam logic [2:0] INVTLB_ALL1        = 3'd1;
  localparam logic [2:0] INVTLB_G1          = 3'd2;
  localparam logic [2:0] INVTLB_G0          = 3'd3;
  localparam logic [2:0] INVTLB_G0_ASID     = 3'd4;
  localparam logic [2:0] INVTLB_G0_ASID_VA  = 3'd5;
  localparam logic [2:0] INVTLB_GA_VA       = 3'd6;
  localparam logic [4:0] INVTLB_LAST        = 5'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Feedback tap mask for a maximal-length Fibonacci LFSR of the given width
  function automatic logic [31:0] lfsr_taps(input int iw);
    case (iw)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      default: lfsr_taps = 32'h0000_0003;
    endcase
  endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// rtl/tlb_inv_match.sv - combinational INVTLB entry match function
module tlb_inv_match
  import tlb_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [9:0]  op_asid,
  input  logic [18:0] op_vppn,
  input  logic        ent_g,
  input  logic [9:0]  ent_asid,
  input  logic [18:0] ent_vppn,
  output logic        hit
);

  logic asid_eq;
  logic vppn_eq;

  assign asid_eq = (op_asid == ent_asid);
  assign vppn_eq = (op_vppn == ent_vppn);

  always_comb begin
    hit = 1'b0;
    case (op)
      INVTLB_ALL0,
      INVTLB_ALL1:       hit = 1'b1;
      INVTLB_G1:         hit = ent_g;
      INVTLB_G0:         hit = !ent_g;
      INVTLB_G0_ASID:    hit = !ent_g && asid_eq;
      INVTLB_G0_ASID_VA: hit = !ent_g && asid_eq && vppn_eq;
      INVTLB_GA_VA:      hit = (ent_g || asid_eq) && vppn_eq;
      default:           hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// rtl/tlb_maint_ctrl.sv - TLB write/fill/INVTLB sequencer; TLB_FILL_LFSR_EN selects an LFSR fill index
module tlb_maint_ctrl
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = TLBNUM_DEFAULT,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [IW-1:0] req_index,
  input  logic [4:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [18:0]   inv_vppn,
  output logic [IW-1:0] ent_rd_index,
  input  logic          ent_e,
  input  logic          ent_g,
  input  logic [9:0]    ent_asid,
  input  logic [18:0]   ent_vppn,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic          tlb_w_clear,
  output logic          done,
  output logic          err,
  output logic          busy
);

  localparam logic [IW-1:0] LAST_IDX = IW'(TLBNUM - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] fill_q, fill_d;
  logic [2:0]    op_q, op_d;
  logic [9:0]    asid_q, asid_d;
  logic [18:0]   vppn_q, vppn_d;
  logic          err_q, err_d;
  logic          hit;

`ifdef TLB_FILL_LFSR_EN
  localparam logic [IW-1:0] FILL_SEED = IW'(1);
  localparam logic [IW-1:0] FILL_TAPS = lfsr_taps(IW)[IW-1:0];

  always_comb fill_d = {fill_q[IW-2:0], ^(fill_q & FILL_TAPS)};
`else
  localparam logic [IW-1:0] FILL_SEED = '0;

  always_comb fill_d = (fill_q == LAST_IDX) ? '0 : fill_q + IW'(1);
`endif

  // Match is evaluated against the latched operands only, so the requester may
  // change inv_* freely once the walk has started.
  tlb_inv_match u_match (
    .op       (op_q),
    .op_asid  (asid_q),
    .op_vppn  (vppn_q),
    .ent_g    (ent_g),
    .ent_asid (ent_asid),
    .ent_vppn (ent_vppn),
    .hit      (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fill_q  <= FILL_SEED;
      op_q    <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      op_q    <= op_d;
      asid_q  <= asid_d;
      vppn_q  <= vppn_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    asid_d       = asid_q;
    vppn_d       = vppn_q;
    err_d        = err_q;
    req_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    tlb_we       = 1'b0;
    tlb_w_index  = '0;
    tlb_w_clear  = 1'b0;
    ent_rd_index = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          case (req_op_e'(req_op))
            OP_WR: begin
              tlb_we      = 1'b1;
              tlb_w_index = req_index;
            end
            OP_FILL: begin
              tlb_we      = 1'b1;
              tlb_w_index = fill_q;
            end
            OP_INV: begin
              if (inv_op <= INVTLB_LAST) begin
                op_d    = inv_op[2:0];
                asid_d  = inv_asid;
                vppn_d  = inv_vppn;
                cnt_d   = '0;
                state_d = ST_WALK;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_WALK: begin
        busy         = 1'b1;
        ent_rd_index = cnt_q;
        if (ent_e && hit) begin
          tlb_we      = 1'b1;
          tlb_w_index = cnt_q;
          tlb_w_clear = 1'b1;
        end
        cnt_d = cnt_q + IW'(1);
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// tb/tb_tlb_maint_ctrl.sv - directed self-checking bench for tlb_maint_ctrl
module tb_tlb_maint_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_index;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic [4:0]  ent_rd_index;
  logic        ent_e;
  logic        ent_g;
  logic [9:0]  ent_asid;
  logic [18:0] ent_vppn;
  logic        tlb_we;
  logic [4:0]  tlb_w_index;
  logic        tlb_w_clear;
  logic        done;
  logic        err;
  logic        busy;

  logic        m_e    [32];
  logic        m_g    [32];
  logic [9:0]  m_asid [32];
  logic [18:0] m_vppn [32];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] map;
  int          nwe;
  int          nbad;
  logic        d_seen;
  logic        e_seen;

  always #5 clk = ~clk;

  assign ent_e    = m_e[ent_rd_index];
  assign ent_g    = m_g[ent_rd_index];
  assign ent_asid = m_asid[ent_rd_index];
  assign ent_vppn = m_vppn[ent_rd_index];

  tlb_maint_ctrl #(.TLBNUM(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_index    (req_index),
    .inv_op       (inv_op),
    .inv_asid     (inv_asid),
    .inv_vppn     (inv_vppn),
    .ent_rd_index (ent_rd_index),
    .ent_e        (ent_e),
    .ent_g        (ent_g),
    .ent_asid     (ent_asid),
    .ent_vppn     (ent_vppn),
    .tlb_we       (tlb_we),
    .tlb_w_index  (tlb_w_index),
    .tlb_w_clear  (tlb_w_clear),
    .done         (done),
    .err          (err),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one INVTLB, walks all 32 cycles and scrambles the live operands
  // mid-walk; reports cleared-index map, write count, ordering errors, done/err.
  task automatic run_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn,
                         output logic [31:0] cmap, output int cwe, output int cbad,
                         output logic cdone, output logic cerr);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    @(negedge clk);
    req_valid = 1'b0;
    cmap = '0; cwe = 0; cbad = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        inv_op = 5'd0; inv_asid = ~asid; inv_vppn = ~vppn;
      end
      #1;
      if (tlb_we === 1'b1) begin
        cwe++;
        cmap[tlb_w_index] = 1'b1;
        if (tlb_w_index !== 5'(i) || tlb_w_clear !== 1'b1) cbad++;
      end
      if (busy !== 1'b1 || ent_rd_index !== 5'(i) || req_ready !== 1'b0) cbad++;
      @(negedge clk);
    end
    #1;
    cdone = done; cerr = err;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_index = 5'd0;
    inv_op = 5'd0; inv_asid = 10'd0; inv_vppn = 19'd0;
    for (int i = 0; i < 32; i++) begin
      m_e[i] = 1'b1; m_g[i] = 1'b0; m_asid[i] = 10'h000; m_vppn[i] = 19'h0;
    end

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy_done_err_we", {busy, done, err, tlb_we}, 0);
    chk("rst_rd_index", ent_rd_index, 0);

    // FILL index follows the free-running counter from reset release
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1;
    #1;
    chk("fill1_we_clr", {tlb_we, tlb_w_clear}, 2'b10);
    chk("fill1_index", tlb_w_index, 5);
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("fill1_done", {done, err, req_ready}, 3'b100);
    @(negedge clk); req_valid = 1'b1; req_op = 2'd1;
    #1;
    chk("fill2_index", {tlb_we, tlb_w_index}, {1'b1, 5'd7});
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);

    // WR index 7
    req_valid = 1'b1; req_op = 2'd0; req_index = 5'd7;
    #1;
    chk("wr7_write", {tlb_we, tlb_w_clear, tlb_w_index}, {1'b1, 1'b0, 5'd7});
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("wr7_done", {done, err, tlb_we, req_ready}, 4'b1000);
    @(negedge clk);
    #1;
    chk("wr7_idle", {done, req_ready, busy}, 3'b010);

    // INV op 0 with every entry valid
    run_inv(5'd0, 10'h000, 19'h0, map, nwe, nbad, d_seen, e_seen);
    chk("inv0_map", map, 32'hFFFF_FFFF);
    chk("inv0_nwe", nwe, 32);
    chk("inv0_order", nbad, 0);
    chk("inv0_done_err", {d_seen, e_seen}, 2'b10);

    for (int i = 0; i < 32; i++) begin
      m_e[i] = 1'b1; m_g[i] = 1'b0; m_asid[i] = 10'h012; m_vppn[i] = 19'h00abd;
    end
    m_vppn[9]  = 19'h00abc;
    m_g[20]    = 1'b1; m_vppn[20] = 19'h00abc;
    m_e[25]    = 1'b0; m_vppn[25] = 19'h00abc;
    m_g[3]     = 1'b1; m_asid[3]  = 10'h034; m_vppn[3] = 19'h00001;

    run_inv(5'd5, 10'h012, 19'h00abc, map, nwe, nbad, d_seen, e_seen);
    chk("inv5_map", map, 32'h0000_0200);
    chk("inv5_nwe", nwe, 1);
    chk("inv5_done_err", {d_seen, e_seen, nbad[0]}, 3'b100);

    run_inv(5'd2, 10'h012, 19'h00abc, map, nwe, nbad, d_seen, e_seen);
    chk("inv2_map", map, 32'h0010_0008);

    run_inv(5'd6, 10'h012, 19'h00abc, map, nwe, nbad, d_seen, e_seen);
    chk("inv6_map", map, 32'h0010_0200);

    run_inv(5'd4, 10'h012, 19'h00abc, map, nwe, nbad, d_seen, e_seen);
    chk("inv4_map", map, 32'hFDEF_FFF7);
    chk("inv4_order", nbad, 0);

    // Illegal INVTLB op
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; inv_op = 5'd7;
    #1;
    chk("inv7_no_we", tlb_we, 0);
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("inv7_done_err", {done, err, tlb_we, busy}, 4'b1100);
    @(negedge clk);
    #1;
    chk("inv7_idle", {done, err, req_ready}, 3'b001);

    // Reserved request op 3
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd3;
    #1;
    chk("op3_no_we", tlb_we, 0);
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("op3_done_err", {done, err, tlb_we}, 3'b110);
    @(negedge clk);

    // Reset during walk cycle 10
    for (int i = 0; i < 32; i++) m_e[i] = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; inv_op = 5'd0;
    @(negedge clk); req_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("walk10_pre", {busy, tlb_we, tlb_w_index}, {1'b1, 1'b1, 5'd10});
    rst = 1'b0;
    #1;
    chk("rst_mid_walk", {tlb_we, busy, done}, 3'b000);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", {req_ready, busy, tlb_we}, 3'b100);
    @(negedge clk);
    #1;
    chk("post_rst_no_resume", {busy, tlb_we, ent_rd_index}, 0);
    req_valid = 1'b1; req_op = 2'd0; req_index = 5'd3;
    #1;
    chk("wr3_write", {tlb_we, tlb_w_clear, tlb_w_index}, {1'b1, 1'b0, 5'd3});
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("wr3_done", {done, err}, 2'b10);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_maint_ctrl.md
TLB_MAINT_CTRL -- requirements
Module: tlb_maint_ctrl

Interface
REQ-001 SHALL take parameter TLBNUM, default 32, giving the TLB entry count; IW = $clog2(TLBNUM).
REQ-002 SHALL have clk  in  1  single clock; all state is clocked on its rising edge.
REQ-003 SHALL have rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have req_valid in 1, req_ready out 1, and req_op in 2, where op encoding is 0=WR, 1=FILL, 2=INV.
REQ-005 SHALL have req_index in IW, the WR target index.
REQ-006 SHALL have inv_op in 5, inv_asid in 10, and inv_vppn in 19, the INVTLB operands.
REQ-007 SHALL have ent_rd_index out IW, and ent_e, ent_g, ent_asid[9:0], ent_vppn[18:0] in; the entry read port is combinational, returning data in the same cycle.
REQ-008 SHALL have tlb_we out 1, tlb_w_index out IW, and tlb_w_clear out 1, where clear=1 means write e=0 only.
REQ-009 SHALL have done out 1, a one-cycle completion pulse; err out 1, an illegal inv_op flag valid with done; and busy out 1.

Function
REQ-010 SHALL implement FSM states IDLE, WALK, and DONE.
REQ-011 In IDLE, req_ready=1; a handshake occurs when req_valid && req_ready.
REQ-012 For WR, in the handshake cycle: tlb_we=1, tlb_w_index=req_index, tlb_w_clear=0; next cycle is DONE; total latency 1.
REQ-013 For FILL, in the handshake cycle: tlb_we=1, tlb_w_index=fill_idx, tlb_w_clear=0; next cycle is DONE.
REQ-014 fill_idx SHALL be a free-running IW-bit counter incrementing every cycle and wrapping TLBNUM-1 -> 0, unaffected by requests.
REQ-015 For INV with legal inv_op, the block SHALL latch the operands, clear walk counter cnt to 0, and enter WALK; busy=1 and req_ready=0 until DONE.
REQ-016 In WALK, ent_rd_index=cnt; if ent_e && match(inv_op), then tlb_we=1, tlb_w_index=cnt, tlb_w_clear=1 in the same cycle.
REQ-017 Match SHALL be defined as: op 0,1 all; op 2 g=1; op 3 g=0; op 4 g=0 && asid eq; op 5 g=0 && asid eq && vppn eq; op 6 (g=1 || asid eq) && vppn eq.
REQ-018 cnt SHALL increment once per WALK cycle; after cnt=TLBNUM-1 the FSM goes to DONE; WALK takes exactly TLBNUM cycles.
REQ-019 INV with inv_op>6 SHALL write nothing and go directly to DONE with err=1.
REQ-020 DONE SHALL last one cycle with done=1 and req_ready=0, then return to IDLE.
REQ-021 A new request SHALL be accepted only in IDLE; there are no back-to-back handshakes, so the minimum spacing is 2 cycles.
REQ-022 req_op=3 SHALL be treated as illegal: no write, DONE, err=1.
REQ-023 Operand changes during WALK SHALL be ignored, since only latched copies are used.
REQ-024 Outside the cases above, tlb_we=0, tlb_w_clear=0, and ent_rd_index=0.

Reset
REQ-025 Asserting rst at any time, including mid-WALK, SHALL force IDLE with cnt=0, fill_idx=0 (LFSR seed 1 when enabled), latched operands 0, and outputs tlb_we=0, done=0, err=0, busy=0, req_ready=1 after release.
REQ-026 A WALK interrupted by reset SHALL NOT be resumed.

Configuration
REQ-027 With macro TLB_FILL_LFSR_EN defined, fill_idx SHALL come from an IW-bit maximal-length Fibonacci LFSR (seed 1, never 0; for IW=5, taps 5,3) and only index TLBNUM-1..1 values are produced; 0 is not produced.
REQ-028 Without the macro, fill_idx SHALL be the wrapping counter of REQ-014.

Structure
REQ-029 Shared package tlb_pkg SHALL hold the op encodings (WR/FILL/INV), INVTLB op constants 0..6, and the default TLBNUM.
REQ-030 Sub-module tlb_inv_match SHALL be the combinational match function of REQ-017.
REQ-031 Everything else SHALL be kept in a single module.

Verification
REQ-032 Scenario WR: WR index 7 -> the same cycle has tlb_we=1, index 7, clear 0; the next cycle has done=1, err=0.
REQ-033 Scenario INV op 0: INV op 0 with all 32 entries e=1 -> 32 consecutive clears at indices 0..31; done at cycle 33; err=0.
REQ-034 Scenario INV op 5: INV op 5, asid 0x12, vppn 0x00abc, with a matching g=0 entry only at index 9 and the same entry with g=1 at index 20 -> exactly one clear, at index 9.
REQ-035 Scenario illegal op: INV op 7 -> no tlb_we; done=1 and err=1 one cycle after the handshake.
REQ-036 Scenario reset: reset asserted at walk cycle 10 -> tlb_we=0 immediately; after release, req_ready=1 and a subsequent WR index 3 completes normally.
REQ-037 Scenario FILL (counter build): FILL issued at reset release +5 cycles -> index 5; a second FILL 2 cycles later -> index 7.
